// File: rtl/data_bus.sv
// rtl/data_bus.sv - data-memory subsystem: word RAM, console TX FIFO and cycle counter behind an MMIO window
module data_bus #(
    parameter int              XLEN       = 32,
    parameter int              RAM_WORDS  = 1024,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [XLEN-1:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr_memory,
    input  logic [XLEN-1:0] write_data_memory,
    input  logic            we_memory_memory,
    output logic [XLEN-1:0] read_data,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * 4);

    logic [XLEN-1:0] r_ram  [RAM_WORDS];
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [FAW-1:0]  r_wptr;
    logic [FAW-1:0]  r_rptr;
    logic [FAW:0]    r_count;
    logic            r_ovf;
    logic [63:0]     r_cycle;

    logic            w_is_ram;
    logic            w_is_mmio;
    logic [1:0]      w_off;
    logic [RAW-1:0]  w_ram_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_accept;
    logic            w_drop;
    logic            w_ovf_clr;
    logic [XLEN-1:0] w_status;

    assign w_is_ram  = addr_memory < RAM_BYTES;
    assign w_is_mmio = addr_memory[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
    assign w_off     = addr_memory[3:2];
    assign w_ram_idx = addr_memory[RAW+1:2];

    assign w_full    = r_count == (FAW+1)'(FIFO_DEPTH);
    assign w_empty   = r_count == '0;
    assign w_pop     = !w_empty && tx_ready;
    assign w_push    = we_memory_memory && w_is_mmio && (w_off == 2'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_ovf_clr = we_memory_memory && w_is_mmio && (w_off == 2'd1) && write_data_memory[2];

    assign tx_data   = r_fifo[r_rptr];
    assign tx_valid  = !w_empty;

    always_comb begin
        w_status       = '0;
        w_status[15:8] = 8'(r_count);
        w_status[2]    = r_ovf;
        w_status[1]    = w_empty;
        w_status[0]    = w_full;
    end

    always_comb begin
        read_data = '0;
        if (w_is_ram) begin
            read_data = r_ram[w_ram_idx];
        end else if (w_is_mmio) begin
            case (w_off)
                2'd1:    read_data = w_status;
                2'd2:    read_data = XLEN'(r_cycle[31:0]);
                2'd3:    read_data = XLEN'(r_cycle[63:32]);
                default: read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we_memory_memory && w_is_ram) begin
            r_ram[w_ram_idx] <= write_data_memory;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wptr] <= write_data_memory[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end
endmodule
